// File: rtl/router_out_arbiter_pkg.sv
// Shared types for the 2x2 router output arbiter: flit format, flit kinds and arbiter FSM states.
// Flits carry an 8-bit payload alongside the routing fields so individual flits stay distinguishable.
package router_out_arbiter_pkg;

    localparam int NUM_PORTS = 2;
    localparam int DEST_W    = $clog2(NUM_PORTS);
    localparam int DATA_W    = 8;

    typedef enum logic [1:0] {
        FLIT_HEAD   = 2'd0,
        FLIT_BODY   = 2'd1,
        FLIT_TAIL   = 2'd2,
        FLIT_SINGLE = 2'd3
    } flit_type_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    typedef struct packed {
        flit_type_t          ftype;
        logic [DEST_W-1:0]   dest;
        logic [DATA_W-1:0]   data;
    } pkt_flit_t;

    // HEAD and SINGLE are the only flits that may open a new packet on an idle output.
    function automatic logic is_start(flit_type_t t);
        return (t == FLIT_HEAD) || (t == FLIT_SINGLE);
    endfunction

    function automatic logic is_end(flit_type_t t);
        return (t == FLIT_TAIL) || (t == FLIT_SINGLE);
    endfunction

endpackage

// File: rtl/router_out_arbiter_if.sv
// FIFO-drain and output-link signals of one router output arbiter.
// Output link: a flit transfers on a clock edge where out_valid && out_ready; out_pkt is stable while out_valid && !out_ready.
interface router_out_arbiter_if #(
    parameter int CNT_WIDTH = 16
);

    router_out_arbiter_pkg::pkt_flit_t  fifo_out_pkt_0;
    logic                               fifo_empty_0;
    logic                               read_0;
    router_out_arbiter_pkg::pkt_flit_t  fifo_out_pkt_1;
    logic                               fifo_empty_1;
    logic                               read_1;
    router_out_arbiter_pkg::pkt_flit_t  out_pkt;
    logic                               out_valid;
    logic                               out_ready;
    logic [CNT_WIDTH-1:0]               pkt_count;
    logic                               proto_err;
    router_out_arbiter_pkg::arb_state_t state;

    modport slave (
        input  fifo_out_pkt_0, fifo_empty_0, fifo_out_pkt_1, fifo_empty_1, out_ready,
        output read_0, read_1, out_pkt, out_valid, pkt_count, proto_err, state
    );

    modport master (
        output fifo_out_pkt_0, fifo_empty_0, fifo_out_pkt_1, fifo_empty_1, out_ready,
        input  read_0, read_1, out_pkt, out_valid, pkt_count, proto_err, state
    );

endinterface

// File: rtl/router_out_arbiter_rr_arb2.sv
// Two-requester round-robin picker: on a tie the requester that did not win last time is granted.
module router_rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = req_i;
        if (req_i == 2'b11) begin
            grant_o = last_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/router_out_arbiter.sv
// Output-port arbiter: drains packets for PORT_ID from two input FIFOs round-robin, with wormhole
// locking from HEAD to TAIL, through a single registered valid/ready output stage.
module router_out_arbiter
    import router_out_arbiter_pkg::*;
#(
    parameter int PORT_ID   = 0,
    parameter int CNT_WIDTH = 16
) (
    input logic                  clk,
    input logic                  rst_b,
    router_out_arbiter_if.slave  bus
);

    arb_state_t           state_q, state_d;
    logic                 owner_q, owner_d;
    logic                 rr_last_q, rr_last_d;
    logic                 proto_err_q, proto_err_d;
    pkt_flit_t            out_pkt_q;
    logic                 out_valid_q;
    logic [CNT_WIDTH-1:0] pkt_count_q;

    logic       slot_free;
    logic [1:0] req;
    logic [1:0] grant;
    logic       pop;
    logic       pop_src;
    pkt_flit_t  pop_flit;
    pkt_flit_t  owner_flit;
    pkt_flit_t  grant_flit;
    logic       owner_empty;

    assign slot_free = !out_valid_q || bus.out_ready;

    // Only packet openers addressed to this port compete; BODY/TAIL at a front belong to another output.
    assign req[0] = !bus.fifo_empty_0 && is_start(bus.fifo_out_pkt_0.ftype)
                    && (bus.fifo_out_pkt_0.dest == DEST_W'(PORT_ID));
    assign req[1] = !bus.fifo_empty_1 && is_start(bus.fifo_out_pkt_1.ftype)
                    && (bus.fifo_out_pkt_1.dest == DEST_W'(PORT_ID));

    router_rr_arb2 u_rr_arb (
        .req_i   (req),
        .last_i  (rr_last_q),
        .grant_o (grant)
    );

    assign owner_flit  = owner_q  ? bus.fifo_out_pkt_1 : bus.fifo_out_pkt_0;
    assign owner_empty = owner_q  ? bus.fifo_empty_1   : bus.fifo_empty_0;
    assign grant_flit  = grant[1] ? bus.fifo_out_pkt_1 : bus.fifo_out_pkt_0;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= ARB_IDLE;
            owner_q     <= 1'b0;
            rr_last_q   <= 1'b1;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_last_q   <= rr_last_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_last_d   = rr_last_q;
        proto_err_d = proto_err_q;
        pop         = 1'b0;
        pop_src     = owner_q;
        case (state_q)
            ARB_IDLE: begin
                if (slot_free && (grant != 2'b00)) begin
                    pop       = 1'b1;
                    pop_src   = grant[1];
                    rr_last_d = grant[1];
                    if (grant_flit.ftype == FLIT_HEAD) begin
                        state_d = ARB_BUSY;
                        owner_d = grant[1];
                    end
                end
            end
            ARB_BUSY: begin
                // A new opener behind an unfinished packet is a sender bug; park rather than corrupt the worm.
                if (!owner_empty) begin
                    if (is_start(owner_flit.ftype)) begin
                        proto_err_d = 1'b1;
                    end else if (slot_free) begin
                        pop = 1'b1;
                        if (owner_flit.ftype == FLIT_TAIL) begin
                            state_d = ARB_IDLE;
                        end
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        bus.read_0 = pop && !pop_src;
        bus.read_1 = pop && pop_src;
        pop_flit   = pop_src ? bus.fifo_out_pkt_1 : bus.fifo_out_pkt_0;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            out_pkt_q   <= '0;
            out_valid_q <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            if (pop) begin
                out_pkt_q   <= pop_flit;
                out_valid_q <= 1'b1;
            end else if (slot_free) begin
                out_valid_q <= 1'b0;
            end
            if (out_valid_q && bus.out_ready && is_end(out_pkt_q.ftype)
                && (pkt_count_q != {CNT_WIDTH{1'b1}})) begin
                pkt_count_q <= pkt_count_q + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.out_pkt   = out_pkt_q;
    assign bus.out_valid = out_valid_q;
    assign bus.pkt_count = pkt_count_q;
    assign bus.proto_err = proto_err_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_router_out_arbiter.sv
// Directed bench for router_out_arbiter: two FIFO models feed the arbiter, a monitor checks every
// accepted output flit against an expected queue filled when stimulus is issued.
module tb_router_out_arbiter;
    import router_out_arbiter_pkg::*;

    localparam int CW = 4;
    localparam int W  = $bits(pkt_flit_t);

    logic clk   = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    router_out_arbiter_if #(.CNT_WIDTH(CW)) bus ();

    router_out_arbiter #(.PORT_ID(0), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [W-1:0] exp_q[$];
    pkt_flit_t  q0[$];
    pkt_flit_t  q1[$];
    logic       cap_r0, cap_r1;
    logic       stalled = 1'b0;
    pkt_flit_t  held_pkt;

    function automatic pkt_flit_t mk(flit_type_t t, logic d, logic [7:0] v);
        pkt_flit_t f;
        f.ftype = t;
        f.dest  = d;
        f.data  = v;
        return f;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic refresh();
        bus.fifo_empty_0   = (q0.size() == 0);
        bus.fifo_out_pkt_0 = (q0.size() != 0) ? q0[0] : '0;
        bus.fifo_empty_1   = (q1.size() == 0);
        bus.fifo_out_pkt_1 = (q1.size() != 0) ? q1[0] : '0;
    endtask

    task automatic push0(pkt_flit_t f, bit expect_out);
        q0.push_back(f);
        if (expect_out) exp_q.push_back(f);
        refresh();
    endtask

    task automatic push1(pkt_flit_t f, bit expect_out);
        q1.push_back(f);
        if (expect_out) exp_q.push_back(f);
        refresh();
    endtask

    // One clock: sample pops before the edge, apply them to the FIFO models after it, return at negedge+1.
    task automatic step();
        #1;
        cap_r0 = bus.read_0;
        cap_r1 = bus.read_1;
        @(posedge clk);
        #1;
        if (rst_b) begin
            chk("read0_when_empty", cap_r0 && (q0.size() == 0), 0);
            chk("read1_when_empty", cap_r1 && (q1.size() == 0), 0);
            chk("both_reads", cap_r0 && cap_r1, 0);
            if (cap_r0 && q0.size() != 0) void'(q0.pop_front());
            if (cap_r1 && q1.size() != 0) void'(q1.pop_front());
        end
        refresh();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 200) begin
            step();
            n++;
        end
        chk("drain_timeout", n < 200, 1);
    endtask

    task automatic check_reset_vals();
        chk("rst_out_pkt", bus.out_pkt, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_read_0", bus.read_0, 0);
        chk("rst_read_1", bus.read_1, 0);
        chk("rst_pkt_count", bus.pkt_count, 0);
        chk("rst_proto_err", bus.proto_err, 0);
        chk("rst_state", bus.state, ARB_IDLE);
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        q0.delete();
        q1.delete();
        exp_q.delete();
        refresh();
        #1;
        check_reset_vals();
        step();
        step();
        rst_b = 1'b1;
    endtask

    // Monitor: every accepted flit must be the next expected one; a stalled flit must not change.
    always @(negedge clk) begin
        #3;
        if (!rst_b) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_pkt", bus.out_pkt, held_pkt);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL spurious_flit: got %0h expected none at %0t", bus.out_pkt, $time);
                end else begin
                    chk("flit", bus.out_pkt, exp_q.pop_front());
                end
            end
            stalled  = bus.out_valid && !bus.out_ready;
            held_pkt = bus.out_pkt;
        end
    end

    initial begin
        logic rd_tab[5];
        logic ov_tab[5];
        bus.out_ready = 1'b1;
        refresh();
        @(negedge clk);
        #1;
        do_reset();

        // Single packet HEAD/BODY/TAIL from input 0.
        rd_tab = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        ov_tab = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        push0(mk(FLIT_HEAD, 1'b0, 8'h10), 1);
        push0(mk(FLIT_BODY, 1'b0, 8'h11), 1);
        push0(mk(FLIT_TAIL, 1'b0, 8'h12), 1);
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("single_read_0", bus.read_0, rd_tab[i]);
            chk("single_out_valid", bus.out_valid, ov_tab[i]);
            step();
        end
        wait_drain();
        chk("single_pkt_count", bus.pkt_count, 1);

        // Contention right after reset: input 0 first, then input 1, next tie back to input 0.
        do_reset();
        push0(mk(FLIT_HEAD, 1'b0, 8'h20), 1);
        push0(mk(FLIT_BODY, 1'b0, 8'h21), 1);
        push0(mk(FLIT_TAIL, 1'b0, 8'h22), 1);
        push1(mk(FLIT_HEAD, 1'b0, 8'h30), 1);
        push1(mk(FLIT_TAIL, 1'b0, 8'h31), 1);
        #1;
        chk("tie1_read_0", bus.read_0, 1);
        chk("tie1_read_1", bus.read_1, 0);
        wait_drain();
        push0(mk(FLIT_SINGLE, 1'b0, 8'h40), 1);
        push1(mk(FLIT_SINGLE, 1'b0, 8'h50), 1);
        #1;
        chk("tie2_read_0", bus.read_0, 1);
        chk("tie2_read_1", bus.read_1, 0);
        wait_drain();
        chk("contention_pkt_count", bus.pkt_count, 4);

        // Wormhole lock: input 1 owns the output while its FIFO runs dry.
        push1(mk(FLIT_HEAD, 1'b0, 8'h60), 1);
        step();
        chk("lock_state_busy", bus.state, ARB_BUSY);
        push0(mk(FLIT_SINGLE, 1'b0, 8'h70), 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("lock_read_0", cap_r0, 0);
        end
        chk("lock_out_valid_dropped", bus.out_valid, 0);
        push1(mk(FLIT_TAIL, 1'b0, 8'h61), 1);
        exp_q.push_back(mk(FLIT_SINGLE, 1'b0, 8'h70));
        #1;
        chk("unlock_read_1", bus.read_1, 1);
        chk("unlock_read_0", bus.read_0, 0);
        wait_drain();
        chk("lock_pkt_count", bus.pkt_count, 6);

        // Backpressure for 4 cycles with BODY 0x81 parked in the output register.
        push0(mk(FLIT_HEAD, 1'b0, 8'h80), 1);
        push0(mk(FLIT_BODY, 1'b0, 8'h81), 1);
        push0(mk(FLIT_BODY, 1'b0, 8'h82), 1);
        push0(mk(FLIT_TAIL, 1'b0, 8'h83), 1);
        step();
        step();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_read_0", cap_r0, 0);
            chk("bp_read_1", cap_r1, 0);
            chk("bp_out_data", bus.out_pkt.data, 8'h81);
            chk("bp_out_valid", bus.out_valid, 1);
        end
        bus.out_ready = 1'b1;
        wait_drain();
        chk("bp_pkt_count", bus.pkt_count, 7);

        // Filtering: input 1 HEAD for the other port is never popped.
        push1(mk(FLIT_HEAD, 1'b1, 8'h90), 0);
        push0(mk(FLIT_SINGLE, 1'b0, 8'hA0), 1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("filter_read_1", cap_r1, 0);
        end
        chk("filter_q1_kept", q1.size(), 1);
        wait_drain();
        chk("filter_pkt_count", bus.pkt_count, 8);

        // Protocol error: second HEAD at the owner front while BUSY.
        push0(mk(FLIT_HEAD, 1'b0, 8'hB0), 1);
        push0(mk(FLIT_HEAD, 1'b0, 8'hB1), 0);
        for (int i = 0; i < 4; i++) step();
        chk("err_flag", bus.proto_err, 1);
        chk("err_state", bus.state, ARB_BUSY);
        chk("err_not_popped", q0.size(), 1);
        chk("err_exp_drained", exp_q.size(), 0);
        for (int i = 0; i < 3; i++) step();
        chk("err_sticky", bus.proto_err, 1);
        do_reset();

        // Counter saturation with a 4-bit counter.
        for (int i = 0; i < 15; i++) push0(mk(FLIT_SINGLE, 1'b0, 8'hC0 + 8'(i)), 1);
        wait_drain();
        chk("sat_reach_max", bus.pkt_count, 15);
        push0(mk(FLIT_SINGLE, 1'b0, 8'hD0), 1);
        push0(mk(FLIT_SINGLE, 1'b0, 8'hD1), 1);
        wait_drain();
        chk("sat_hold_max", bus.pkt_count, 15);

        // Reset mid-packet with a stalled flit in the output register.
        bus.out_ready = 1'b0;
        push0(mk(FLIT_HEAD, 1'b0, 8'hE0), 0);
        push0(mk(FLIT_BODY, 1'b0, 8'hE1), 0);
        step();
        step();
        chk("midpkt_out_valid", bus.out_valid, 1);
        chk("midpkt_state", bus.state, ARB_BUSY);
        do_reset();
        bus.out_ready = 1'b1;
        push0(mk(FLIT_SINGLE, 1'b0, 8'hF0), 1);
        wait_drain();
        chk("post_reset_pkt_count", bus.pkt_count, 1);

        chk("exp_q_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/router_out_arbiter.md
Name: router_out_arbiter

Overview:
- Drain side of the per-input router_fifo instances in the 2x2 router: one arbiter per output port.
- Watches the head flit of both input FIFOs and selects packets addressed to its output port round-robin.
- Pops flits from the selected FIFO and drives them onto the output link through a registered valid/ready stage.
- Wormhole locking: once a HEAD flit is granted, the same source owns the output until its TAIL flit.

Parameters:
- PORT_ID, 0, output port index this arbiter serves; compared with the flit dest field.
- CNT_WIDTH, 16, width of the forwarded-packet counter.

Ports:
- clk  input  1  clock
- rst_b  input  1  reset, asynchronous, active-low
- fifo_out_pkt_0  input  pkt_flit_t  head flit of input-0 FIFO (valid when fifo_empty_0=0)
- fifo_empty_0  input  1  input-0 FIFO empty
- read_0  output  1  pop input-0 FIFO this cycle
- fifo_out_pkt_1  input  pkt_flit_t  head flit of input-1 FIFO
- fifo_empty_1  input  1  input-1 FIFO empty
- read_1  output  1  pop input-1 FIFO this cycle
- out_pkt  output  pkt_flit_t  output link flit
- out_valid  output  1  out_pkt valid
- out_ready  input  1  downstream accepts out_pkt
- pkt_count  output  CNT_WIDTH  TAIL/SINGLE flits accepted downstream, saturating
- proto_err  output  1  sticky protocol-error flag

Behaviour:
- Reset values: out_pkt='0, out_valid=0, read_0=read_1=0, pkt_count=0, proto_err=0, state=IDLE, owner=0, rr_last=1 (input 0 wins the first tie).
- Output register:
  - slot_free = !out_valid || out_ready.
  - A pop loads the popped flit into out_pkt and sets out_valid=1 on the same edge.
  - If slot_free with no pop, out_valid becomes 0.
  - out_pkt is held stable while out_valid && !out_ready.
  - Latency is 1 cycle from pop to out_valid.
- read_x is combinational, never asserted when fifo_empty_x=1, and at most one of read_0/read_1 is high per cycle.
- Eligibility in IDLE: source x is eligible if !fifo_empty_x, head ftype is HEAD or SINGLE, and head dest==PORT_ID.
- FSM:
  - IDLE, nothing eligible or !slot_free: no pop.
  - IDLE, one eligible source and slot_free: pop it.
  - IDLE, both eligible and slot_free: pop the source != rr_last.
  - After an IDLE pop: rr_last <= granted source. SINGLE stays in IDLE. HEAD sets owner <= granted source and goes to BUSY.
  - BUSY: read_owner = !fifo_empty_owner && slot_free. The other FIFO is never popped while BUSY.
  - BUSY, popped flit is TAIL: go to IDLE.
  - BUSY, popped flit is BODY: stay in BUSY.
  - BUSY, owner front flit is HEAD/SINGLE: set proto_err=1, do not pop, stay in BUSY. proto_err clears only on reset.
  - BUSY, owner FIFO empty: wait with no timeout. out_valid drops once the last flit is accepted.
- IDLE with a BODY/TAIL flit at a FIFO front: that source is not eligible, since the flit belongs to another output. No error is raised.
- pkt_count increments when out_valid && out_ready && out_pkt.ftype is TAIL or SINGLE. It saturates at all-ones.
- A same-cycle IDLE->grant and downstream accept is legal; the next flit streams with no bubble. Sustained throughput is 1 flit/cycle while out_ready=1.
- Reset mid-packet: all state returns to reset values and any partially forwarded packet is dropped. The FIFOs are reset by the same rst_b.

Decomposition:
- Shared package / design_includes.h: pkt_flit_t with fields ftype and dest.
- flit_type_t enum: FLIT_HEAD, FLIT_BODY, FLIT_TAIL, FLIT_SINGLE.
- arb_state_t enum: ARB_IDLE, ARB_BUSY.
- NUM_PORTS=2 constant.
- One sub-module: router_rr_arb2, a 2-requester round-robin picker (req[1:0], last -> grant[1:0]), combinational.

Test Plan:
- Single packet: FIFO0 holds HEAD(dest=PORT_ID),BODY,TAIL, out_ready=1 -> read_0 pulses for 3 consecutive cycles, out_valid high for 3 cycles starting 1 cycle later, pkt_count=1.
- Contention: both FIFOs present HEAD(dest=PORT_ID) in the same cycle after reset -> input 0 forwarded fully first, then input 1; the next tie grants input 0.
- Lock: while BUSY on input 1 with its FIFO empty, FIFO0 holds an eligible HEAD -> read_0 stays 0 until input 1's TAIL is popped.
- Backpressure: out_ready=0 for 4 cycles mid-packet -> out_pkt held stable, no read_x asserted, no flit lost or duplicated; stream resumes when out_ready=1.
- Filtering/error: FIFO1 HEAD with dest!=PORT_ID -> never popped. Owner front shows HEAD while BUSY -> proto_err=1, held until rst_b low.
- Saturation/reset: force pkt_count to all-ones, send a SINGLE -> pkt_count stays all-ones; assert rst_b mid-packet -> all outputs return to reset values asynchronously.
